// File: rtl/instr_fetch_if.sv
// Byte-wide instruction-memory read bus with a req/ack handshake.
// The fetch unit is the master; the memory responder is the slave.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch responder: assembles a little-endian 32-bit word from
// four byte reads, with a one-entry line buffer for repeated fetches.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        fetch_req,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misaligned,
  output logic        stall,
  instr_fetch_if.master mem
);

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          misaligned_q, misaligned_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] data_q, data_d;
  logic          buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_tag_q, buf_tag_d;
  logic [AW-1:0] buf_data_q, buf_data_d;
  logic          flush_seen_q, flush_seen_d;
  logic          hit;

  assign hit = buf_valid_q && (buf_tag_q == pc_in) && !flush;

  // Next-state, datapath and stall decode
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    base_d        = base_q;
    beat_d        = beat_q;
    data_d        = data_q;
    buf_valid_d   = buf_valid_q && !flush;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
    flush_seen_d  = flush_seen_q;
    stall         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          if (pc_in[1:0] != 2'b00) begin
            misaligned_d  = 1'b1;
            instr_valid_d = 1'b1;
            instr_d       = NOP_INSTR;
          end else if (hit) begin
            instr_valid_d = 1'b1;
            instr_d       = buf_data_q;
          end else begin
            stall        = 1'b1;
            base_d       = pc_in;
            beat_d       = '0;
            mem_req_d    = 1'b1;
            mem_addr_d   = pc_in;
            flush_seen_d = 1'b0;
            state_d      = S_READ;
          end
        end
      end

      S_READ: begin
        stall = 1'b1;
        if (flush) flush_seen_d = 1'b1;
        if (mem.mem_ack) begin
          case (beat_q)
            2'd0:    data_d[7:0]   = mem.mem_rdata;
            2'd1:    data_d[15:8]  = mem.mem_rdata;
            2'd2:    data_d[23:16] = mem.mem_rdata;
            default: data_d[31:24] = mem.mem_rdata;
          endcase
          beat_d = BW'(beat_q + 2'd1);
          if (beat_q == 2'd3) begin
            state_d       = S_DONE;
            mem_req_d     = 1'b0;
            instr_d       = data_d;
            instr_valid_d = 1'b1;
          end else begin
            mem_addr_d = base_q + AW'(beat_q) + 32'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        // A flush anywhere in this fetch leaves the buffer invalid
        if (!flush_seen_q && !flush) begin
          buf_valid_d = 1'b1;
          buf_tag_d   = base_q;
          buf_data_d  = data_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      base_q        <= '0;
      beat_q        <= '0;
      data_q        <= '0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= '0;
      buf_data_q    <= '0;
      flush_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      base_q        <= base_d;
      beat_q        <= beat_d;
      data_q        <= data_d;
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      flush_seen_q  <= flush_seen_d;
    end
  end

  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign misaligned   = misaligned_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory responder with optional
// wait states, and hand-computed expected words and latencies.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic        fetch_req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misaligned;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic        ack_block = 1'b0;
  logic [31:0] hold_addr = 32'hDEAD_BEEF;
  int          hold_n    = 0;
  int          hold_cnt  = 0;
  int          last_held = 0;

  always #5 clk = ~clk;

  instr_fetch_if mif();

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .fetch_req   (fetch_req),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .stall       (stall),
    .mem         (mif)
  );

  // Memory contents: program bytes at 0x100, address-derived pattern elsewhere
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: mem_byte = 8'h13;
      32'h101: mem_byte = 8'h05;
      32'h102: mem_byte = 8'hA0;
      32'h103: mem_byte = 8'h00;
      default: mem_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Counts consecutive cycles spent requesting hold_addr to insert wait states
  always @(posedge clk) begin
    if (mif.mem_req && mif.mem_addr == hold_addr) hold_cnt <= hold_cnt + 1;
    else hold_cnt <= 0;
  end

  assign mif.mem_ack   = mif.mem_req && !ack_block &&
                         !(mif.mem_addr == hold_addr && hold_cnt < hold_n);
  assign mif.mem_rdata = mem_byte(mif.mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] pc, input bit flush_now,
                          input int flush_cyc, input int exp_lat, input logic [31:0] exp_instr,
                          input bit exp_mis, input int exp_beats);
    int lat, beats, held, addr_err, stall_err;
    pc_in = pc; fetch_req = 1'b1; flush = flush_now;
    #1;
    check({tag, ".stall_req"}, 32'(stall), 32'(exp_beats > 0));
    @(posedge clk); #1;
    fetch_req = 1'b0; flush = 1'b0;
    lat = 1; beats = 0; held = 0; addr_err = 0; stall_err = 0;
    while (!instr_valid && lat < 20) begin
      flush = (lat == flush_cyc);
      if (!stall) stall_err++;
      if (mif.mem_req && mif.mem_addr == hold_addr) held++;
      if (mif.mem_req && mif.mem_ack) begin
        if (mif.mem_addr !== pc + 32'(beats)) addr_err++;
        beats++;
      end
      @(posedge clk); #1;
      lat++;
    end
    flush = 1'b0;
    last_held = held;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".instr"}, instr, exp_instr);
    check({tag, ".misaligned"}, 32'(misaligned), 32'(exp_mis));
    check({tag, ".beats"}, 32'(beats), 32'(exp_beats));
    check({tag, ".addr_err"}, 32'(addr_err), 32'd0);
    check({tag, ".stall_err"}, 32'(stall_err), 32'd0);
    check({tag, ".mem_req_done"}, 32'(mif.mem_req), 32'd0);
    @(posedge clk); #1;
    check({tag, ".valid_once"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #12;
    check("rst.instr", instr, 32'h0000_0013);
    check("rst.valid", 32'(instr_valid), 32'd0);
    check("rst.mis", 32'(misaligned), 32'd0);
    check("rst.mem_req", 32'(mif.mem_req), 32'd0);
    check("rst.mem_addr", mif.mem_addr, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_fetch("miss100", 32'h100, 1'b0, 0, 5, 32'h00A0_0513, 1'b0, 4);
    do_fetch("hit100", 32'h100, 1'b0, 0, 1, 32'h00A0_0513, 1'b0, 0);

    // Held request on a buffered address strobes every cycle
    pc_in = 32'h100; fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("b2b.valid", 32'(instr_valid), 32'd1);
      check("b2b.mem_req", 32'(mif.mem_req), 32'd0);
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;

    do_fetch("flushmiss", 32'h100, 1'b1, 0, 5, 32'h00A0_0513, 1'b0, 4);
    do_fetch("rehit", 32'h100, 1'b0, 0, 1, 32'h00A0_0513, 1'b0, 0);

    hold_addr = 32'h102; hold_n = 2;
    do_fetch("wait", 32'h100, 1'b1, 0, 7, 32'h00A0_0513, 1'b0, 4);
    check("wait.addr_hold", 32'(last_held), 32'd3);
    hold_n = 0; hold_addr = 32'hDEAD_BEEF;

    do_fetch("misal", 32'h102, 1'b0, 0, 1, 32'h0000_0013, 1'b1, 0);
    do_fetch("hit_after_misal", 32'h100, 1'b0, 0, 1, 32'h00A0_0513, 1'b0, 0);

    do_fetch("wrap_flush", 32'hFFFF_FFFC, 1'b0, 2, 5, 32'hA5A4_A7A6, 1'b0, 4);
    do_fetch("wrap_refetch", 32'hFFFF_FFFC, 1'b0, 0, 5, 32'hA5A4_A7A6, 1'b0, 4);

    // Reset in the middle of a stalled read
    ack_block = 1'b1;
    pc_in = 32'h0; fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    check("midread.mem_req", 32'(mif.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.mem_req", 32'(mif.mem_req), 32'd0);
    check("midrst.instr", instr, 32'h0000_0013);
    check("midrst.valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_block = 1'b0;
    @(posedge clk); #1;
    do_fetch("post_rst", 32'h0, 1'b0, 0, 5, 32'h5958_5B5A, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
